// File: rtl/nnrv_trace_tx.sv
// Retire-trace serialiser: buffers retired-instruction records and streams each one as a UART 8N1 frame.
// Define NNRV_TRACE_CKSUM_EN to append an XOR checksum byte (frame grows from 14 to 15 bytes).
module nnrv_trace_tx #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_rd_we,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RW = 102;
`ifdef NNRV_TRACE_CKSUM_EN
  localparam int NBYTES = 15;
`else
  localparam int NBYTES = 14;
`endif
  localparam int FW = NBYTES * 8;
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_BYTE = 4'(NBYTES - 1);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [FW-1:0] frame, frame_load;
  logic [111:0]  base;
  logic [15:0]   div_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_cnt;
  logic          empty, full, div_end, pop, push;
  logic [RW-1:0] head;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign div_end = (div_cnt == DIV_LAST);
  assign head    = mem[rd_ptr];
  // A pop happens on leaving IDLE or at the end of a frame's last stop bit, which is what keeps frames gapless.
  assign pop     = !empty && ((state == IDLE) || (state == STOP && div_end && byte_cnt == 4'd0));
  assign push    = i_valid && (!full || pop);
  assign o_busy  = (state != IDLE) || !empty;

  // Record layout: {rd_data, rd_we, rd_addr, instr, pc}; frame is shifted out from bit 0.
  always_comb begin
    base = {head[101:70], head[69], 2'b00, head[68:64], head[63:32], head[31:0], 8'hA5};
`ifdef NNRV_TRACE_CKSUM_EN
    begin
      logic [7:0] cksum;
      cksum = 8'h00;
      for (int i = 1; i < 14; i++) cksum = cksum ^ base[i*8 +: 8];
      frame_load = {cksum, base};
    end
`else
    frame_load = base;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_rd_data, i_rd_we, i_rd_addr, i_instr, i_pc};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (i_valid && !push) o_overflow <= 1'b1;
    end
  end

  // o_tx mirrors the line level of the current state one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_tx     <= 1'b1;
      frame    <= '0;
      div_cnt  <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        START:   o_tx <= 1'b0;
        DATA:    o_tx <= frame[0];
        default: o_tx <= 1'b1;
      endcase
      case (state)
        IDLE: begin
          if (pop) begin
            frame    <= frame_load;
            byte_cnt <= LAST_BYTE;
            div_cnt  <= '0;
            state    <= START;
          end
        end
        START: begin
          if (div_end) begin
            div_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        DATA: begin
          if (div_end) begin
            div_cnt <= '0;
            frame   <= frame >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        STOP: begin
          if (div_end) begin
            div_cnt <= '0;
            if (byte_cnt != 4'd0) begin
              byte_cnt <= byte_cnt - 4'd1;
              state    <= START;
            end else if (pop) begin
              frame    <= frame_load;
              byte_cnt <= LAST_BYTE;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nnrv_trace_tx.sv
// Directed and randomized bench for nnrv_trace_tx: a UART line monitor decodes o_tx and
// a byte-level frame model supplies the expected stream.
module tb_nnrv_trace_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef NNRV_TRACE_CKSUM_EN
  localparam int NB = 15;
`else
  localparam int NB = 14;
`endif
  localparam int BYTE_T  = 10 * CLK_DIV;
  localparam int FRAME_T = NB * BYTE_T;
  localparam int CAP     = FIFO_DEPTH + 1;
  localparam int HALF    = CLK_DIV / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] pc = '0, instr = '0, rd_data = '0;
  logic        rd_we = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic        tx, busy, ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int frame_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];

  nnrv_trace_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_pc(pc), .i_instr(instr),
    .i_rd_we(rd_we), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_tx(tx), .o_busy(busy), .o_overflow(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // UART line monitor: samples mid-bit on the falling edge.
  bit         mon_on = 1'b0;
  int         mon_k, mon_t, mon_idx;
  logic [7:0] mon_byte;
  always @(negedge clk) begin
    if (rst) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (tx === 1'b0) begin
        mon_on = 1'b1;
        mon_k  = 0;
        mon_t  = cyc;
      end
    end else begin
      mon_k++;
      if (mon_k == HALF) begin
        if (tx !== 1'b0) begin
          frame_err++;
          mon_on = 1'b0;
        end
      end else if (mon_k > HALF && (mon_k - HALF) % CLK_DIV == 0) begin
        mon_idx = (mon_k - HALF) / CLK_DIV;
        if (mon_idx <= 8) begin
          mon_byte[mon_idx-1] = tx;
        end else begin
          if (tx === 1'b1) begin
            rx_q.push_back(mon_byte);
            rx_t.push_back(mon_t);
          end else begin
            frame_err++;
          end
          mon_on = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rec(input logic [31:0] p, input logic [31:0] ins, input logic w,
                         input logic [4:0] a, input logic [31:0] d);
    pc = p; instr = ins; rd_we = w; rd_addr = a; rd_data = d;
    valid = 1'b1;
  endtask

  // Fields carry junk while valid is low; they must be ignored.
  task automatic clear_rec();
    valid   = 1'b0;
    pc      = $urandom;
    instr   = $urandom;
    rd_we   = 1'($urandom_range(0, 1));
    rd_addr = 5'($urandom_range(0, 31));
    rd_data = $urandom;
  endtask

  // scoreboard: frame model built straight from the byte ordering rule
  function automatic void model_push(input logic [31:0] p, input logic [31:0] ins, input logic w,
                                     input logic [4:0] a, input logic [31:0] d);
    logic [7:0] b[$];
    b.push_back(8'hA5);
    for (int i = 0; i < 4; i++) b.push_back(8'((p >> (8 * i)) & 32'hFF));
    for (int i = 0; i < 4; i++) b.push_back(8'((ins >> (8 * i)) & 32'hFF));
    b.push_back(8'(w) * 8'd128 + 8'(a));
    for (int i = 0; i < 4; i++) b.push_back(8'((d >> (8 * i)) & 32'hFF));
`ifdef NNRV_TRACE_CKSUM_EN
    begin
      logic [7:0] ck;
      ck = 8'h00;
      for (int i = 1; i < b.size(); i++) ck = ck ^ b[i];
      b.push_back(ck);
    end
`endif
    foreach (b[i]) exp_q.push_back(b[i]);
  endfunction

  task automatic random_rec(input bit to_model);
    logic [31:0] p, ins, d;
    logic        w;
    logic [4:0]  a;
    p = $urandom; ins = $urandom; d = $urandom;
    w = 1'($urandom_range(0, 1)); a = 5'($urandom_range(0, 31));
    set_rec(p, ins, w, a, d);
    if (to_model) model_push(p, ins, w, a, d);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < limit) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, 32'(k < limit), 32'd1);
    repeat (2 * CLK_DIV) tick();
  endtask

  task automatic compare_frames(input string tag, input bit all_gaps);
    int n, bad;
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
    bad = 0;
    for (int i = 1; i < rx_t.size(); i++)
      if ((all_gaps || (i % NB) != 0) && (rx_t[i] - rx_t[i-1] != BYTE_T)) bad++;
    check({tag, "_gaps"}, bad, 0);
    check({tag, "_framing"}, frame_err, 0);
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
  endtask

  logic [7:0] ref040 [14];
  int low;

  initial begin
    ref040 = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
               8'h81, 8'h01, 8'h00, 8'h00, 8'h00};

    // reset state and idle line
    rst = 1'b1;
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    clear_rec();
    low = 0;
    repeat (20) begin
      tick();
      if (tx !== 1'b1) low++;
    end
    check("idle_high", low, 0);

    // reference record: latency, frame length, busy release
    set_rec(32'h4, 32'h0010_0093, 1'b1, 5'd1, 32'h1);
    model_push(32'h4, 32'h0010_0093, 1'b1, 5'd1, 32'h1);
    tick();
    clear_rec();
    check("lat_edge_n", tx, 1);
    tick();
    check("lat_edge_n1", tx, 1);
    tick();
    check("lat_edge_n2", tx, 0);
    repeat (FRAME_T - 2) tick();
    check("busy_in_last_stop", busy, 1);
    repeat (2) tick();
    check("busy_after_frame", busy, 0);
    check("tx_after_frame", tx, 1);
    wait_idle("ref", 100);
    check("ref_nbytes_min", 32'(rx_q.size() >= 14), 1);
    if (rx_q.size() >= NB) begin
      for (int i = 0; i < 14; i++) check($sformatf("ref_const_b%0d", i), rx_q[i], ref040[i]);
      check("ref_frame_len", rx_t[NB-1] - rx_t[0] + BYTE_T, FRAME_T);
    end
    compare_frames("ref", 1'b1);

    // non-writing retire keeps rd_data bytes
    begin
      logic [31:0] p, ins, d;
      p = $urandom; ins = $urandom; d = $urandom;
      set_rec(p, ins, 1'b0, 5'd5, d);
      model_push(p, ins, 1'b0, 5'd5, d);
      tick();
      clear_rec();
      wait_idle("nowr", FRAME_T + 100);
      if (rx_q.size() > 9) check("nowr_byte10", rx_q[9], 8'h05);
      compare_frames("nowr", 1'b1);
    end

    // random bursts that fit the buffer
    for (int burst = 0; burst < 4; burst++) begin
      int n;
      n = $urandom_range(1, CAP);
      for (int j = 0; j < n; j++) begin
        random_rec(1'b1);
        tick();
        if (j < n - 1) begin
          int gap;
          gap = $urandom_range(0, 3);
          if (gap > 0) begin
            clear_rec();
            repeat (gap) tick();
          end
        end
      end
      clear_rec();
      wait_idle($sformatf("burst%0d", burst), CAP * FRAME_T + 100);
      compare_frames($sformatf("burst%0d", burst), 1'b0);
    end
    check("no_ovf_after_bursts", ovf, 0);

    // overflow: six consecutive records from idle
    for (int j = 0; j < CAP + 1; j++) begin
      random_rec(j < CAP);
      tick();
      if (j == CAP - 1) check("ovf_before_drop", ovf, 0);
    end
    clear_rec();
    check("ovf_set", ovf, 1);
    wait_idle("ovf", (CAP + 1) * FRAME_T + 100);
    compare_frames("ovf", 1'b1);
    check("ovf_sticky", ovf, 1);

    // reset during byte 5 aborts the frame for good
    random_rec(1'b0);
    tick();
    clear_rec();
    repeat (2 + 4 * BYTE_T + 15) tick();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_ovf_cleared", ovf, 0);
    rst = 1'b0;
    low = 0;
    repeat (3 * BYTE_T) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) low++;
    end
    check("abort_quiet", low, 0);
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
    frame_err = 0;
    random_rec(1'b1);
    tick();
    clear_rec();
    wait_idle("fresh", FRAME_T + 100);
    compare_frames("fresh", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
